// File: rtl/sha256_job_ctrl.sv
// sha256_job_ctrl: deserialises 80-byte jobs for sha256_double, launches a search, streams back a 37-byte result frame
module sha256_job_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1048576
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [7:0]            m_data,
  input  logic                  m_ready,
  output logic                  hash_in_valid,
  output logic [11:0][7:0]      hash_in_data,
  output logic [7:0][31:0]      hash_in_state,
  output logic [31:0]           hash_in_nonce_base,
  output logic [31:0][7:0]      hash_in_target,
  output logic [31:0]           hash_in_position,
  input  logic                  hash_out_valid,
  input  logic [31:0][7:0]      hash_out_result,
  input  logic [31:0]           hash_out_nonce
);
  typedef enum logic [1:0] {RX, LAUNCH, SEARCH, TX} state_t;
  state_t           state;
  logic [6:0]       idx;
  logic [5:0]       tx_idx;
  logic [31:0]      cnt;
  logic             first;
  logic [7:0]       status;
  logic [31:0]      nonce;
  logic [31:0][7:0] result;
  logic [6:0]       so;
  logic [5:0]       tn;
  logic [7:0]       nxt_byte;
  logic             take;
  assign hash_in_position = '0;
  // frame byte tn: 1..4 are nonce bytes MSB first, 5..36 are result[31]..result[0]
  always_comb begin
    so = idx - 7'd12;
    tn = tx_idx + 6'd1;
    take = s_valid && s_ready;
    nxt_byte = tn < 6'd5 ? nonce[{2'(3'd4 - tn[2:0]), 3'b000} +: 8] : result[5'(6'd36 - tn)];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_data <= '0;
      hash_in_valid <= 1'b0;
      hash_in_data <= '0;
      hash_in_state <= '0;
      hash_in_nonce_base <= '0;
      hash_in_target <= '0;
      idx <= '0;
      tx_idx <= '0;
      cnt <= '0;
      first <= 1'b0;
      status <= '0;
      nonce <= '0;
      result <= '0;
    end else begin
      case (state)
        RX: begin
          s_ready <= 1'b1;
          if (take) begin
            if (idx < 7'd12) hash_in_data[idx[3:0]] <= s_data;
            else if (idx < 7'd44) hash_in_state[so[4:2]][{2'd3 - so[1:0], 3'b000} +: 8] <= s_data;
            else if (idx < 7'd48) hash_in_nonce_base[{2'd3 - idx[1:0], 3'b000} +: 8] <= s_data;
            else hash_in_target[5'(7'd79 - idx)] <= s_data;
            idx <= idx == 7'd79 ? 7'd0 : idx + 7'd1;
            if (idx == 7'd79) begin
              state <= LAUNCH;
              s_ready <= 1'b0;
              hash_in_valid <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          hash_in_valid <= 1'b0;
          cnt <= '0;
          first <= 1'b1;
          state <= SEARCH;
        end
        SEARCH: begin
          first <= 1'b0;
          // first cycle ignores found so a level held over from the previous job is not captured
          if (hash_out_valid && !first) begin
            status <= 8'h01;
            nonce <= hash_out_nonce;
            result <= hash_out_result;
            m_data <= 8'h01;
            m_valid <= 1'b1;
            tx_idx <= '0;
            state <= TX;
          end else if (cnt == TIMEOUT_CYCLES - 32'd1) begin
            status <= 8'h00;
            nonce <= '0;
            result <= '0;
            m_data <= 8'h00;
            m_valid <= 1'b1;
            tx_idx <= '0;
            state <= TX;
          end else cnt <= cnt + 32'd1;
        end
        TX: begin
          if (m_ready) begin
            if (tx_idx == 6'd36) begin
              m_valid <= 1'b0;
              s_ready <= 1'b1;
              state <= RX;
            end else begin
              tx_idx <= tn;
              m_data <= nxt_byte;
            end
          end
        end
        default: state <= RX;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_job_ctrl.sv
// tb_sha256_job_ctrl: scoreboard bench with a stub search core driving the found/timeout paths
module tb_sha256_job_ctrl;
  logic             clk = 1'b0, rst = 1'b1;
  logic             s_valid = 1'b0, s_ready;
  logic [7:0]       s_data = '0;
  logic             m_valid, m_ready = 1'b1;
  logic [7:0]       m_data;
  logic             hash_in_valid;
  logic [11:0][7:0] hash_in_data;
  logic [7:0][31:0] hash_in_state;
  logic [31:0]      hash_in_nonce_base, hash_in_position;
  logic [31:0][7:0] hash_in_target;
  logic             hash_out_valid = 1'b0;
  logic [31:0][7:0] hash_out_result = '0;
  logic [31:0]      hash_out_nonce = '0;

  always #5 clk = ~clk;

  sha256_job_ctrl #(.TIMEOUT_CYCLES(32'd1000)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .hash_in_valid(hash_in_valid), .hash_in_data(hash_in_data), .hash_in_state(hash_in_state),
    .hash_in_nonce_base(hash_in_nonce_base), .hash_in_target(hash_in_target),
    .hash_in_position(hash_in_position),
    .hash_out_valid(hash_out_valid), .hash_out_result(hash_out_result), .hash_out_nonce(hash_out_nonce)
  );

  int n_checks = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0]   job [80];
  logic [639:0] launch_q [$];
  logic [7:0]   out_q [$];
  bit           rand_ready = 1'b0, gaps = 1'b0;
  int           frames_done = 0;

  function automatic void make_job(input logic [31:0] nb, input bit ff_target);
    for (int i = 0; i < 80; i++) job[i] = 8'(i);
    {job[12], job[13], job[14], job[15]} = 32'h6a09e667;
    {job[44], job[45], job[46], job[47]} = nb;
    if (ff_target) for (int i = 48; i < 80; i++) job[i] = 8'hff;
  endfunction

  function automatic logic [31:0][7:0] mk_r(input logic [7:0] seed);
    logic [31:0][7:0] r;
    for (int k = 0; k < 32; k++) r[k] = seed ^ 8'(k * 13);
    return r;
  endfunction

  task automatic push_frame(input logic [7:0] st, input logic [31:0] n, input logic [31:0][7:0] r);
    out_q.push_back(st);
    for (int k = 3; k >= 0; k--) out_q.push_back(n[8*k +: 8]);
    for (int k = 31; k >= 0; k--) out_q.push_back(r[k]);
  endtask

  task automatic send_bytes(input int n, input bit full);
    logic [639:0] p;
    logic acc;
    if (full) begin
      for (int i = 0; i < 80; i++) p[8*i +: 8] = job[i];
      launch_q.push_back(p);
    end
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data = job[i];
      for (int t = 0; t <= 60; t++) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk); #1;
        if (acc) break;
        if (t == 60) check("s_ready_wait", 0, 1);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic raise_found(input logic [31:0] n, input logic [31:0][7:0] r);
    push_frame(8'h01, n, r);
    hash_out_nonce = n;
    hash_out_result = r;
    hash_out_valid = 1'b1;
    @(posedge clk); #1;
    check("found_latency", m_valid, 1);
    hash_out_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    for (int t = 0; t < 3000 && frames_done < n; t++) @(posedge clk);
    check("frames_done", frames_done, n);
  endtask

  initial forever begin
    @(posedge clk); #1;
    m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor: launch fields, outbound scoreboard, stall stability, s_ready while busy
  initial begin
    logic [639:0]     p;
    logic [11:0][7:0] ed;
    logic [7:0][31:0] es;
    logic [31:0]      en;
    logic [31:0][7:0] et;
    logic             prev_stall, busy, prev_hv;
    logic [7:0]       prev_data;
    int               in_cnt, out_cnt;
    prev_stall = 0; busy = 0; prev_hv = 0; prev_data = 0; in_cnt = 0; out_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0; busy = 0; prev_hv = 0; in_cnt = 0; out_cnt = 0;
      end else begin
        if (busy) check("s_ready_busy", s_ready, 0);
        if (prev_stall) check("stall_hold", {m_valid, m_data}, {1'b1, prev_data});
        if (prev_hv) check("launch_pulse", hash_in_valid, 0);
        if (s_valid && s_ready) in_cnt++;
        if (hash_in_valid && !prev_hv) begin
          check("in_bytes", in_cnt, 80);
          in_cnt = 0;
          busy = 1;
          if (launch_q.size() == 0) check("spurious_launch", 1, 0);
          else begin
            p = launch_q.pop_front();
            for (int i = 0; i < 12; i++) ed[i] = p[8*i +: 8];
            for (int w = 0; w < 8; w++)
              es[w] = {p[8*(12+4*w) +: 8], p[8*(13+4*w) +: 8], p[8*(14+4*w) +: 8], p[8*(15+4*w) +: 8]};
            en = {p[8*44 +: 8], p[8*45 +: 8], p[8*46 +: 8], p[8*47 +: 8]};
            for (int k = 0; k < 32; k++) et[31-k] = p[8*(48+k) +: 8];
            check("launch_data_eq", hash_in_data == ed, 1);
            check("launch_state_eq", hash_in_state == es, 1);
            check("launch_state0", hash_in_state[0], es[0]);
            check("launch_nonce_base", hash_in_nonce_base, en);
            check("launch_target_eq", hash_in_target == et, 1);
          end
        end
        if (m_valid && m_ready) begin
          if (out_q.size() == 0) check("tx_unexpected", 1, 0);
          else check("tx_byte", m_data, out_q.pop_front());
          out_cnt++;
          if (out_cnt == 37) begin
            out_cnt = 0;
            frames_done++;
            busy = 0;
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data = m_data;
        prev_hv = hash_in_valid;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_hash_in_valid", hash_in_valid, 0);
    check("rst_nonce_base", hash_in_nonce_base, 0);
    check("rst_position", hash_in_position, 0);
    check("rst_state_zero", hash_in_state == '0, 1);
    check("rst_target_zero", hash_in_target == '0, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("s_ready_after_rst", s_ready, 1);

    // mapping plus found path with m_ready held high
    make_job(32'h10, 1'b0);
    send_bytes(80, 1'b1);
    check("launch_valid", hash_in_valid, 1);
    check("map_state0", hash_in_state[0], 32'h6a09e667);
    check("map_nonce_base", hash_in_nonce_base, 32'h10);
    check("map_target31", hash_in_target[31], 8'd48);
    check("map_target0", hash_in_target[0], 8'd79);
    repeat (4) @(posedge clk);
    #1;
    check("no_early_result", m_valid, 0);
    raise_found(32'h10, mk_r(8'h5a));
    n = 1;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk); #1;
      if (!m_valid) break;
      n++;
    end
    check("tx_length", n, 37);
    check("s_ready_back", s_ready, 1);

    // back-to-back job under backpressure and inbound gaps
    rand_ready = 1'b1;
    gaps = 1'b1;
    make_job(32'h10, 1'b1);
    send_bytes(80, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    raise_found(32'h13, mk_r(8'hc3));
    wait_frames(2);

    // timeout
    make_job(32'h20, 1'b0);
    send_bytes(80, 1'b1);
    push_frame(8'h00, 32'h0, '0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!m_valid && n < 1200);
    check("timeout_latency", n, 1001);
    wait_frames(3);

    // stale found held across launch must not be captured
    hash_out_nonce = 32'hdeadbeef;
    hash_out_result = mk_r(8'hee);
    hash_out_valid = 1'b1;
    make_job(32'h40, 1'b0);
    send_bytes(80, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    hash_out_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("stale_masked", m_valid, 0);
    raise_found(32'h55, mk_r(8'h21));
    wait_frames(4);

    // reset mid-search: no result frame
    make_job(32'h60, 1'b0);
    send_bytes(80, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_frame_after_rst", m_valid, 0);

    // reset mid-frame, then a full job
    make_job(32'h77, 1'b0);
    for (int i = 0; i < 80; i++) job[i] = job[i] ^ 8'h3c;
    send_bytes(40, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    make_job(32'h99, 1'b1);
    send_bytes(80, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    raise_found(32'h9a, mk_r(8'h77));
    wait_frames(5);

    repeat (5) @(posedge clk);
    check("out_q_empty", out_q.size(), 0);
    check("launch_q_empty", launch_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sha256_job_ctrl.md
# sha256_job_ctrl

Byte-stream job controller that sits between the host link and `sha256_double`, and drives both sides of that search core's interface. It deserialises an 80-byte job frame into the core's data, midstate, nonce-base and target inputs, then launches a search. It waits for a nonce-found indication or a cycle-count timeout. It returns the outcome as a 37-byte result frame on an outbound byte stream.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 32'd1048576: maximum SEARCH cycles before reporting "not found"; legal range 2 .. 2^32-1.

Ports:
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `s_valid` input 1: inbound job byte valid.
- `s_data` input 8: inbound job byte.
- `s_ready` output 1: controller accepts `s_data` this cycle.
- `m_valid` output 1: outbound result byte valid.
- `m_data` output 8: outbound result byte.
- `m_ready` input 1: sink accepts `m_data` this cycle.
- `hash_in_valid` output 1: start pulse to the search core.
- `hash_in_data` output [11:0][7:0]: header tail bytes.
- `hash_in_state` output [7:0][31:0]: SHA-256 midstate.
- `hash_in_nonce_base` output 32: first nonce.
- `hash_in_target` output [31:0][7:0]: target; the found hash is strictly less than this value.
- `hash_in_position` output 32: tied to 0.
- `hash_out_valid` input 1: search core reports nonce found (level, held).
- `hash_out_result` input [31:0][7:0]: winning hash.
- `hash_out_nonce` input 32: winning nonce.

## Operation
- States: RX, LAUNCH, SEARCH, TX.
- RX:
  - `s_ready`=1; a byte transfers when `s_valid && s_ready`.
  - A 7-bit index counts bytes 0..79.
  - Byte mapping:
    - bytes 0..11 -> `hash_in_data[0..11]`.
    - bytes 12..43 -> `hash_in_state[0..7]`, each word big-endian (first byte = bits 31:24).
    - bytes 44..47 -> `hash_in_nonce_base`, big-endian.
    - bytes 48..79 -> `hash_in_target[31..0]` (byte 48 = `target[31]`, most significant).
  - Accepting byte 79 -> LAUNCH.
- LAUNCH:
  - `hash_in_valid`=1 for exactly one cycle; the `hash_in_*` fields are registered and stay stable until the next job.
  - Clear the timeout counter; -> SEARCH.
- SEARCH:
  - `s_ready`=0.
  - `hash_out_valid` is ignored in the first SEARCH cycle, which masks stale found status from the previous job.
  - From the second SEARCH cycle, `hash_out_valid`=1 captures nonce and result, sets status=0x01, -> TX.
  - Otherwise the counter increments. When counter == `TIMEOUT_CYCLES`-1: status=0x00, nonce=0, result=0, -> TX.
  - `hash_out_valid` and timeout in the same cycle: found wins.
- TX:
  - Sends 37 bytes: status; nonce bits 31:24, 23:16, 15:8, 7:0; then `result[31]` down to `result[0]`.
  - `m_data` is stable while `m_valid && !m_ready`.
  - After byte 36 transfers -> RX.
- Inbound bytes presented outside RX are not consumed (`s_ready`=0).

## Timing
- Reset values: state RX; `s_ready`=0 during the reset cycle and 1 from the first cycle after reset deasserts; `m_valid`=0, `m_data`=0, `hash_in_valid`=0, all `hash_in_*` fields 0, index and counters 0.
- Reset mid-frame or mid-search: partial job discarded, no result frame, controller back in RX.
- Launch latency: `hash_in_valid` is high in the cycle after byte 79 transfers.
- Found latency: `m_valid` rises the cycle after `hash_out_valid` is sampled high in SEARCH.
- Timeout: `m_valid` rises exactly `TIMEOUT_CYCLES`+1 cycles after the LAUNCH cycle.
- With `m_ready` held 1, the result frame takes 37 consecutive cycles.
- `s_ready` returns to 1 the cycle after the final TX byte transfers.
- Back-to-back operation: a new job may begin streaming immediately after that cycle.

## Test plan
- Mapping:
  - Stimulus: stream bytes 12..15 = 6a 09 e6 67, bytes 44..47 = 00 00 00 10, other bytes = index value.
  - Required response: one-cycle `hash_in_valid`; `hash_in_state[0]`=32'h6a09e667; `hash_in_nonce_base`=32'h00000010; `hash_in_target[31]`=8'd48; `hash_in_target[0]`=8'd79.
- Found path, real core:
  - Stimulus: target all 0xFF, nonce base 0x00000010.
  - Required response: frame 01 00 00 00 10 followed by 32 hash bytes equal to the core's `out_result` MSB first.
- Timeout, `TIMEOUT_CYCLES`=1000:
  - Stimulus: stub core keeps `hash_out_valid`=0.
  - Required response: `m_valid` rises 1001 cycles after LAUNCH; frame 00 followed by 36 bytes of 00.
- Stale-found masking:
  - Stimulus: stub holds `hash_out_valid`=1 through LAUNCH, drops it before SEARCH cycle 2.
  - Required response: no found capture; search continues.
- Backpressure:
  - Stimulus: toggle `m_ready` pseudo-randomly, and drive `s_valid` with gaps during RX.
  - Required response: `m_data` never changes while stalled; byte counts are exactly 80 in and 37 out; `s_ready`=0 throughout SEARCH and TX.
- Reset mid-frame:
  - Stimulus: assert `rst` after 40 job bytes, then send a full job.
  - Required response: no `hash_in_valid` for the partial job; exactly one launch with the full job's fields.
